// File: rtl/fetch_stage_reg.sv
// Fetch-to-decode pipeline register with stall/flush, a debug run/halt/step
// controller and a PC history ring readable by the debug unit.
module fetch_stage_reg #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned HIST_AW = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               debugReset,
  input  logic               debugMode,
  input  logic               debugStep,
  input  logic [7:0]         debugStepCount,
  input  logic               notEnable,
  input  logic               flush,
  input  logic               validIn,
  input  logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pcOut,
  output logic [INSTR_W-1:0] instrOut,
  output logic               validOut,
  output logic               halted,
  input  logic [HIST_AW-1:0] histAddr,
  output logic [PC_W-1:0]    histPc,
  output logic [HIST_AW:0]   histCount
);

  localparam int unsigned CNT_W = 8;
  localparam logic [HIST_AW:0] HIST_FULL = (HIST_AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               adv_c;
  logic               hist_we_c;

  logic [PC_W-1:0]    hist_q [DEPTH];
  logic [HIST_AW-1:0] wrptr_q;
  logic [HIST_AW-1:0] rd_idx_c;

  assign adv_c     = ((state_q == ST_RUN) || (state_q == ST_STEP)) && !notEnable;
  assign hist_we_c = adv_c && validIn && !flush && !debugReset;

  // Debug controller next state; a flushed cycle never consumes a step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (debugReset) begin
      state_d = debugMode ? ST_HALT : ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (debugMode) state_d = ST_HALT;
        end
        ST_HALT: begin
          if (!debugMode) begin
            state_d = ST_RUN;
          end else if (debugStep) begin
            state_d = ST_STEP;
            cnt_d   = (debugStepCount == 8'd0) ? 8'd1 : debugStepCount;
          end
        end
        ST_STEP: begin
          if (!debugMode) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (adv_c && !flush) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = ST_HALT;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      halted  <= (state_d == ST_HALT);
    end
  end

  // Pipeline register: debugReset > flush > advance > hold.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      pcOut    <= '0;
      instrOut <= '0;
      validOut <= 1'b0;
    end else if (debugReset || flush) begin
      pcOut    <= '0;
      instrOut <= '0;
      validOut <= 1'b0;
    end else if (adv_c) begin
      pcOut    <= pc;
      instrOut <= instr;
      validOut <= validIn;
    end
  end

  // History ring; the pointer wraps naturally since DEPTH == 2**HIST_AW.
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      wrptr_q   <= '0;
      histCount <= '0;
      for (int i = 0; i < int'(DEPTH); i++) hist_q[i] <= '0;
    end else if (debugReset) begin
      wrptr_q   <= '0;
      histCount <= '0;
      for (int i = 0; i < int'(DEPTH); i++) hist_q[i] <= '0;
    end else if (hist_we_c) begin
      hist_q[wrptr_q] <= pc;
      wrptr_q         <= wrptr_q + HIST_AW'(1);
      if (histCount != HIST_FULL) histCount <= histCount + (HIST_AW+1)'(1);
    end
  end

  assign rd_idx_c = wrptr_q - HIST_AW'(1) - histAddr;
  assign histPc   = ({1'b0, histAddr} < histCount) ? hist_q[rd_idx_c] : '0;

endmodule

// File: tb/tb_fetch_stage_reg.sv
// Directed bench for fetch_stage_reg: vector table for free-run/stall/flush,
// hand sequences for debug stepping, history wrap and resets.
module tb_fetch_stage_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic        debugReset, debugMode, debugStep;
  logic [7:0]  debugStepCount;
  logic        notEnable, flush, validIn;
  logic [7:0]  pc;
  logic [31:0] instr;
  logic [7:0]  pcOut;
  logic [31:0] instrOut;
  logic        validOut, halted;
  logic [2:0]  histAddr;
  logic [7:0]  histPc;
  logic [3:0]  histCount;

  int errors = 0;
  int checks = 0;

  fetch_stage_reg dut (
    .clock(clock), .reset(reset), .debugReset(debugReset),
    .debugMode(debugMode), .debugStep(debugStep),
    .debugStepCount(debugStepCount), .notEnable(notEnable),
    .flush(flush), .validIn(validIn), .pc(pc), .instr(instr),
    .pcOut(pcOut), .instrOut(instrOut), .validOut(validOut),
    .halted(halted), .histAddr(histAddr), .histPc(histPc),
    .histCount(histCount)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       ne;
    logic       fl;
    logic       vi;
    logic [7:0] pc;
    logic [2:0] ha;
    logic [7:0] e_pc;
    logic       e_v;
    logic [3:0] e_hc;
    logic [7:0] e_hp;
  } vec_t;

  vec_t vecs [12];

  function automatic vec_t mk(logic ne, logic fl, logic vi, logic [7:0] p,
                              logic [2:0] ha, logic [7:0] e_pc, logic e_v,
                              logic [3:0] e_hc, logic [7:0] e_hp);
    vec_t v;
    v.ne = ne; v.fl = fl; v.vi = vi; v.pc = p; v.ha = ha;
    v.e_pc = e_pc; v.e_v = e_v; v.e_hc = e_hc; v.e_hp = e_hp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; debugReset = 0; debugMode = 0; debugStep = 0;
    debugStepCount = 0; notEnable = 0; flush = 0; validIn = 0;
    pc = 0; instr = 0; histAddr = 0;

    //           ne fl vi  pc     ha  e_pc   ev hc e_hp
    vecs[0]  = mk(0, 0, 1, 8'h10, 0, 8'h10, 1, 1, 8'h10);
    vecs[1]  = mk(0, 0, 1, 8'h11, 0, 8'h11, 1, 2, 8'h11);
    vecs[2]  = mk(0, 0, 1, 8'h12, 0, 8'h12, 1, 3, 8'h12);
    vecs[3]  = mk(0, 0, 0, 8'h13, 2, 8'h13, 0, 3, 8'h10);
    vecs[4]  = mk(0, 0, 1, 8'h1F, 3, 8'h1F, 1, 4, 8'h10);
    vecs[5]  = mk(1, 0, 1, 8'h20, 0, 8'h1F, 1, 4, 8'h1F);
    vecs[6]  = mk(1, 1, 1, 8'h20, 0, 8'h00, 0, 4, 8'h1F);
    vecs[7]  = mk(1, 0, 1, 8'h20, 0, 8'h00, 0, 4, 8'h1F);
    vecs[8]  = mk(0, 0, 1, 8'h20, 0, 8'h20, 1, 5, 8'h20);
    vecs[9]  = mk(0, 1, 1, 8'h21, 0, 8'h00, 0, 5, 8'h20);
    vecs[10] = mk(0, 0, 1, 8'h22, 5, 8'h22, 1, 6, 8'h10);
    vecs[11] = mk(0, 0, 0, 8'h23, 6, 8'h23, 0, 6, 8'h00);

    #3;
    chk("rst pcOut", pcOut, 0);
    chk("rst instrOut", instrOut, 0);
    chk("rst validOut", validOut, 0);
    chk("rst halted", halted, 0);
    chk("rst histCount", histCount, 0);
    chk("rst histPc", histPc, 0);
    #4 reset = 1'b0;

    // Free run, stall and flush
    for (int i = 0; i < 12; i++) begin
      notEnable = vecs[i].ne; flush = vecs[i].fl; validIn = vecs[i].vi;
      pc = vecs[i].pc; instr = {24'hC0DE00, vecs[i].pc}; histAddr = vecs[i].ha;
      tick();
      chk($sformatf("vec%0d pcOut", i), pcOut, vecs[i].e_pc);
      chk($sformatf("vec%0d instrOut", i), instrOut,
          (vecs[i].e_pc == 8'h00) ? 32'h0 : {24'hC0DE00, vecs[i].e_pc});
      chk($sformatf("vec%0d validOut", i), validOut, vecs[i].e_v);
      chk($sformatf("vec%0d halted", i), halted, 0);
      chk($sformatf("vec%0d histCount", i), histCount, vecs[i].e_hc);
      chk($sformatf("vec%0d histPc", i), histPc, vecs[i].e_hp);
    end
    notEnable = 0; flush = 0;

    // debugReset in free run, then history wrap with 11 entries
    debugReset = 1; validIn = 1; pc = 8'h3C; histAddr = 0;
    tick();
    debugReset = 0;
    chk("dbgrst pcOut", pcOut, 0);
    chk("dbgrst halted", halted, 0);
    chk("dbgrst histCount", histCount, 0);
    for (int i = 0; i < 11; i++) begin
      pc = 8'h40 + 8'(i);
      tick();
    end
    chk("wrap histCount", histCount, 8);
    histAddr = 3'd7; #1;
    chk("wrap histPc[7]", histPc, 8'h43);
    histAddr = 3'd0; #1;
    chk("wrap histPc[0]", histPc, 8'h4A);
    chk("wrap pcOut", pcOut, 8'h4A);

    // Enter HALT; the RUN->HALT edge still advances
    debugMode = 1; pc = 8'h2F;
    tick();
    chk("halt enter", halted, 1);
    chk("halt pcOut", pcOut, 8'h2F);
    pc = 8'h33; tick();
    chk("halt hold", pcOut, 8'h2F);

    // Step burst of 3
    debugStep = 1; debugStepCount = 8'd3; pc = 8'h2E;
    tick();
    debugStep = 0;
    chk("step3 enter halted", halted, 0);
    chk("step3 enter pcOut", pcOut, 8'h2F);
    for (int i = 0; i < 6; i++) begin
      pc = 8'h30 + 8'(i);
      tick();
      chk($sformatf("step3 pcOut %0d", i), pcOut, (i < 2) ? 8'h30 + 8'(i) : 8'h32);
      chk($sformatf("step3 halted %0d", i), halted, (i >= 2));
    end

    // Step count 0 means one advance
    debugStep = 1; debugStepCount = 8'd0; pc = 8'h4F;
    tick();
    debugStep = 0;
    chk("step0 enter halted", halted, 0);
    pc = 8'h50; tick();
    chk("step0 pcOut", pcOut, 8'h50);
    chk("step0 halted", halted, 1);
    pc = 8'h51; tick();
    chk("step0 hold", pcOut, 8'h50);

    // Burst of 4 entered under stall, stalled mid-burst, retrigger ignored
    debugStep = 1; debugStepCount = 8'd4; notEnable = 1; pc = 8'h5F;
    tick();
    debugStep = 0;
    chk("step4 enter halted", halted, 0);
    chk("step4 enter pcOut", pcOut, 8'h50);
    for (int i = 0; i < 7; i++) begin
      logic [7:0] exp_pc [7];
      logic       exp_h  [7];
      exp_pc = '{8'h60, 8'h60, 8'h60, 8'h63, 8'h64, 8'h65, 8'h65};
      exp_h  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      notEnable = (i == 1 || i == 2);
      debugStep = (i == 1); debugStepCount = 8'd9;
      pc = 8'h60 + 8'(i);
      tick();
      chk($sformatf("step4 pcOut %0d", i), pcOut, exp_pc[i]);
      chk($sformatf("step4 halted %0d", i), halted, exp_h[i]);
    end
    debugStep = 0; notEnable = 0;

    // Flush while halted clears outputs, stays halted
    flush = 1; pc = 8'h67;
    tick();
    flush = 0;
    chk("haltflush pcOut", pcOut, 0);
    chk("haltflush validOut", validOut, 0);
    chk("haltflush halted", halted, 1);

    // Async reset in the middle of a burst
    debugStep = 1; debugStepCount = 8'd5;
    tick();
    debugStep = 0; pc = 8'h70;
    tick();
    chk("midstep pcOut", pcOut, 8'h70);
    #2 reset = 1'b1;
    #1;
    chk("areset pcOut", pcOut, 0);
    chk("areset instrOut", instrOut, 0);
    chk("areset validOut", validOut, 0);
    chk("areset halted", halted, 0);
    chk("areset histCount", histCount, 0);
    reset = 1'b0; debugMode = 0; pc = 8'h71;
    tick();
    chk("post-reset run pcOut", pcOut, 8'h71);
    chk("post-reset halted", halted, 0);
    chk("post-reset histCount", histCount, 1);

    // debugReset with debugMode=1 lands in HALT
    debugMode = 1; debugReset = 1; pc = 8'h80;
    tick();
    debugReset = 0;
    chk("dbgrst2 pcOut", pcOut, 0);
    chk("dbgrst2 validOut", validOut, 0);
    chk("dbgrst2 histCount", histCount, 0);
    chk("dbgrst2 halted", halted, 1);
    pc = 8'h81; tick();
    chk("dbgrst2 hold", pcOut, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage_reg.md
Name: fetch_stage_reg

Overview:
- Parametrised fetch-stage pipeline register: the successor to the fixed 8-bit fetch PC latch.
- Carries PC, instruction and a valid bit into decode.
- Stall, flush and bubble insertion.
- Debug run/halt/N-step state machine.
- PC history ring buffer, readable by the debug unit.
- Sits between the PC/instruction-memory logic and the decode stage.

Parameters:
PC_W, 8, PC width in bits
INSTR_W, 32, instruction width in bits
DEPTH, 8, PC history entries (power of 2, >=2)
HIST_AW, 3, history address width (=log2 DEPTH)

Ports:
clock  input  1  pipeline clock; all state updates on the falling edge
reset  input  1  asynchronous, active-high reset
debugReset  input  1  synchronous clear of outputs, history and debug FSM
debugMode  input  1  1 = debugger controls advance; 0 = free run
debugStep  input  1  single-cycle pulse: start a step burst (HALT only)
debugStepCount  input  8  number of advances per burst (0 treated as 1)
notEnable  input  1  stall from hazard unit; holds the register
flush  input  1  insert a bubble
validIn  input  1  fetched instruction is real
pc  input  PC_W  fetched PC
instr  input  INSTR_W  fetched instruction
pcOut  output  PC_W  registered PC
instrOut  output  INSTR_W  registered instruction
validOut  output  1  registered valid
halted  output  1  1 when FSM is in HALT
histAddr  input  HIST_AW  history index; 0 = most recent
histPc  output  PC_W  combinational read of history[histAddr]
histCount  output  HIST_AW+1  entries held; saturates at DEPTH

Behaviour:
- Reset (async): pcOut=0, instrOut=0, validOut=0, history cleared, histCount=0, step counter=0, FSM=RUN, halted=0.
- FSM states are RUN, HALT and STEP. halted is registered and equals (state==HALT).
- RUN: if debugMode=1, go to HALT on the next falling edge.
- HALT:
  - If debugMode=0, go to RUN.
  - Else if debugStep=1, go to STEP with counter = max(debugStepCount,1).
- STEP:
  - If debugMode=0, go to RUN.
  - Each advance decrements the counter.
  - An advance with counter==1 updates the register and goes to HALT on the same edge.
  - Stalled cycles do not decrement.
  - debugStep is ignored while in STEP.
- Advance is adv = (state==RUN || state==STEP) && ~notEnable.
- Update priority at each falling edge: reset > debugReset > flush > adv > hold.
  - debugReset: outputs 0, history cleared, counter=0, FSM = HALT if debugMode else RUN.
  - flush: pcOut=0, instrOut=0, validOut=0. Applies even when stalled or halted. Does not consume a step, does not decrement the counter and does not write history. The FSM transitions still evaluate.
  - adv: pcOut=pc, instrOut=instr, validOut=validIn.
  - hold: all outputs unchanged.
- Latency: one falling edge from input to output.
- History:
  - Written on adv && validIn && ~flush.
  - Write pointer is HIST_AW bits and wraps from DEPTH-1 to 0, overwriting the oldest entry.
  - histCount increments and saturates at DEPTH.
  - Read address = wrptr-1-histAddr (mod DEPTH).
  - histPc = 0 when histAddr >= histCount.
- Simultaneous events:
  - debugStep together with notEnable: enter STEP; no advance until the stall clears.
  - debugMode falling during STEP: RUN; the remaining count is discarded (counter=0).
  - reset mid-burst: immediate RUN with cleared state.

Test Plan:
- Free run, debugMode=0, pc=0x10,0x11,0x12 with validIn=1 -> pcOut follows one falling edge later; histCount=3; histPc at histAddr=0 is 0x12, at histAddr=2 is 0x10.
- notEnable=1 for 2 cycles while pc=0x20 is presented -> pcOut holds the prior 0x1F; flush asserted during the stall -> validOut=0, pcOut=0, histCount unchanged.
- debugMode=1 -> halted=1 after one edge; debugStep with debugStepCount=3, pc 0x30..0x35 -> exactly 0x30,0x31,0x32 latched, then halted=1 and pcOut stays 0x32; debugStepCount=0 -> exactly one advance.
- STEP burst of 4 with notEnable asserted for 2 mid-burst cycles -> still exactly 4 advances, and HALT on the 4th.
- Push DEPTH+3 = 11 valid PCs 0x40..0x4A -> histCount=8; histAddr=7 gives 0x43; histAddr=0 gives 0x4A.
- Assert reset asynchronously mid-STEP, between edges -> outputs go to 0 immediately, halted=0, histCount=0; debugReset -> same clear on the falling edge, with halted=1 if debugMode=1.
